// File: rtl/spi_master_ctrl_if.sv
// Data/config side of the SPI master controller: one transmit word in,
// one received word out, plus the per-transfer clock configuration.
interface spi_master_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int PSC_W  = 4
);
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              busy;
    logic [PSC_W-1:0]  psc;
    logic              cpol;
    logic              cpha;

    modport master (
        output tx_valid, tx_data, psc, cpol, cpha,
        input  tx_ready, rx_valid, rx_data, busy
    );

    modport slave (
        input  tx_valid, tx_data, psc, cpol, cpha,
        output tx_ready, rx_valid, rx_data, busy
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// Byte-oriented SPI master: accepts one word, shifts it out MSB first in any
// CPOL/CPHA mode at a prescaled SCK rate and returns the word clocked in on miso.
module spi_master_ctrl #(
    parameter int DATA_W = 8,
    parameter int PSC_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    spi_master_ctrl_if.slave    bus,
    output logic                cs_n,
    output logic                sck,
    output logic                mosi,
    input  logic                miso
);
    localparam int EDGES = 2 * DATA_W;
    localparam int EW    = $clog2(EDGES);
    localparam logic [EW-1:0] LAST_EDGE = EW'(EDGES - 1);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        HOLD
    } state_t;

    state_t            state_reg;
    logic [PSC_W-1:0]  cnt_reg;
    logic [PSC_W-1:0]  psc_reg;
    logic [EW-1:0]     edge_reg;
    logic [DATA_W-1:0] tx_sh_reg;
    logic [DATA_W-1:0] rx_sh_reg;
    logic [DATA_W-1:0] rx_data_reg;
    logic              cpol_reg;
    logic              cpha_reg;
    logic              cs_n_reg;
    logic              sck_reg;
    logic              mosi_reg;
    logic              rx_valid_reg;
    logic              busy_reg;
    logic              tx_ready_reg;

    logic tick;
    logic accept;
    logic sample_edge;
    logic shift_edge;

    assign tick   = (cnt_reg == psc_reg);
    assign accept = tx_ready_reg & bus.tx_valid;

    // Even edge index is the leading edge. With CPHA=1 the MSB is already on
    // mosi when cs_n falls, so the first leading edge must not shift.
    always_comb begin
        sample_edge = 1'b0;
        shift_edge  = 1'b0;
        if (cpha_reg) begin
            sample_edge = edge_reg[0];
            shift_edge  = ~edge_reg[0] && (edge_reg > EW'(1));
        end else begin
            sample_edge = ~edge_reg[0];
            shift_edge  = edge_reg[0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            psc_reg      <= '0;
            edge_reg     <= '0;
            tx_sh_reg    <= '0;
            rx_sh_reg    <= '0;
            rx_data_reg  <= '0;
            cpol_reg     <= 1'b0;
            cpha_reg     <= 1'b0;
            cs_n_reg     <= 1'b1;
            sck_reg      <= 1'b0;
            mosi_reg     <= 1'b0;
            rx_valid_reg <= 1'b0;
            busy_reg     <= 1'b0;
            tx_ready_reg <= 1'b0;
        end else begin
            rx_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    sck_reg      <= bus.cpol;
                    cs_n_reg     <= 1'b1;
                    busy_reg     <= 1'b0;
                    tx_ready_reg <= 1'b1;
                    if (accept) begin
                        state_reg    <= XFER;
                        cs_n_reg     <= 1'b0;
                        busy_reg     <= 1'b1;
                        tx_ready_reg <= 1'b0;
                        tx_sh_reg    <= bus.tx_data;
                        mosi_reg     <= bus.tx_data[DATA_W-1];
                        rx_sh_reg    <= '0;
                        psc_reg      <= bus.psc;
                        cpol_reg     <= bus.cpol;
                        cpha_reg     <= bus.cpha;
                        cnt_reg      <= '0;
                        edge_reg     <= '0;
                    end
                end

                XFER: begin
                    cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
                    if (tick) begin
                        sck_reg  <= ~sck_reg;
                        edge_reg <= edge_reg + 1'b1;
                        if (sample_edge) begin
                            rx_sh_reg <= {rx_sh_reg[DATA_W-2:0], miso};
                        end
                        if (shift_edge) begin
                            tx_sh_reg <= {tx_sh_reg[DATA_W-2:0], 1'b0};
                            mosi_reg  <= tx_sh_reg[DATA_W-2];
                        end
                        if (edge_reg == LAST_EDGE) begin
                            state_reg <= HOLD;
                            edge_reg  <= '0;
                        end
                    end
                end

                // One more half-period with sck parked at idle before cs_n rises.
                HOLD: begin
                    cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
                    if (tick) begin
                        cs_n_reg     <= 1'b1;
                        busy_reg     <= 1'b0;
                        rx_data_reg  <= rx_sh_reg;
                        rx_valid_reg <= 1'b1;
                        state_reg    <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign cs_n         = cs_n_reg;
    assign sck          = sck_reg;
    assign mosi         = mosi_reg;
    assign bus.tx_ready = tx_ready_reg;
    assign bus.rx_valid = rx_valid_reg;
    assign bus.rx_data  = rx_data_reg;
    assign bus.busy     = busy_reg;
endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: pad-level monitor, simple SPI slave model
// and a linear sequence of transfers with hand-computed expectations.
module tb_spi_master_ctrl;
    localparam int DW = 8;
    localparam int PW = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic cs_n, sck, mosi, miso;

    always #5 clk = ~clk;

    spi_master_ctrl_if #(.DATA_W(DW), .PSC_W(PW)) bus ();

    spi_master_ctrl #(.DATA_W(DW), .PSC_W(PW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .cs_n  (cs_n),
        .sck   (sck),
        .mosi  (mosi),
        .miso  (miso)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic       m_cpol   = 1'b0;
    logic       m_cpha   = 1'b0;
    logic       loop_en  = 1'b1;
    logic [7:0] slv_word = 8'h00;

    // Slave: drives slv_word MSB first, captures mosi on its sampling edges.
    logic       slv_bit = 1'b0;
    logic       slv_sck = 1'b0;
    logic [7:0] slv_rx  = 8'h00;
    int         slv_e   = 0;

    assign miso = loop_en ? mosi : slv_bit;

    always @(sck or cs_n or m_cpha or slv_word) begin
        if (cs_n !== 1'b0) begin
            slv_e   <= 0;
            slv_bit <= m_cpha ? 1'b0 : slv_word[7];
        end else if (sck !== slv_sck) begin
            if (slv_e[0] == m_cpha)
                slv_rx <= (slv_e < 2) ? {7'b0, mosi} : {slv_rx[6:0], mosi};
            else if (m_cpha)
                slv_bit <= slv_word[7 - slv_e / 2];
            else if (slv_e < 15)
                slv_bit <= slv_word[7 - (slv_e + 1) / 2];
            slv_e <= slv_e + 1;
        end
        slv_sck <= sck;
    end

    // Pad monitor, sampled on the falling clock edge.
    bit   mon_clr    = 1'b0;
    int   cyc        = 0;
    int   cs_low     = 0;
    int   sck_edges  = 0;
    int   rises      = 0;
    int   bad_mosi   = 0;
    int   rxv_cnt    = 0;
    int   hp_min     = 1000;
    int   hp_max     = 0;
    int   cs_fall    = 0;
    int   cs_rise    = 0;
    int   first_edge = 0;
    int   last_edge  = 0;
    bit   have_edge  = 1'b0;
    logic prev_cs    = 1'b1;
    logic prev_sck   = 1'b0;
    logic prev_mosi  = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (mon_clr) begin
            cs_low    <= 0;
            sck_edges <= 0;
            rises     <= 0;
            bad_mosi  <= 0;
            rxv_cnt   <= 0;
            hp_min    <= 1000;
            hp_max    <= 0;
            have_edge <= 1'b0;
        end else begin
            if (cs_n === 1'b0) cs_low <= cs_low + 1;
            if (prev_cs === 1'b1 && cs_n === 1'b0) cs_fall <= cyc;
            if (prev_cs === 1'b0 && cs_n === 1'b1) cs_rise <= cyc;
            if (cs_n === 1'b0 && sck !== prev_sck) begin
                sck_edges <= sck_edges + 1;
                if (sck === 1'b1) rises <= rises + 1;
                if (have_edge) begin
                    if (cyc - last_edge < hp_min) hp_min <= cyc - last_edge;
                    if (cyc - last_edge > hp_max) hp_max <= cyc - last_edge;
                end else begin
                    first_edge <= cyc;
                end
                have_edge <= 1'b1;
                last_edge <= cyc;
            end
            if (prev_cs === 1'b0 && cs_n === 1'b0 && mosi !== prev_mosi &&
                !(sck !== prev_sck && sck === (m_cpha ? ~m_cpol : m_cpol)))
                bad_mosi <= bad_mosi + 1;
            if (bus.rx_valid === 1'b1) rxv_cnt <= rxv_cnt + 1;
        end
        prev_cs   <= cs_n;
        prev_sck  <= sck;
        prev_mosi <= mosi;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        @(posedge clk);
        #1 mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    task automatic wait_rxv(output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 3000) begin
            @(negedge clk);
            n++;
            if (bus.rx_valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic send(input logic [7:0] d, input bit keep);
        bit ok;
        int n;
        @(posedge clk);
        #1;
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 3000) begin
            @(negedge clk);
            n++;
            if (bus.tx_ready === 1'b1) ok = 1'b1;
        end
        chk("accept", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        if (!keep) bus.tx_valid = 1'b0;
    endtask

    task automatic start_xfer(input logic [7:0] d, input logic [3:0] p, input logic pol,
                              input logic pha, input logic lp, input logic [7:0] sw);
        bus.psc  = p;
        bus.cpol = pol;
        bus.cpha = pha;
        m_cpol   = pol;
        m_cpha   = pha;
        loop_en  = lp;
        slv_word = sw;
        clr_mon();
        send(d, 1'b0);
    endtask

    task automatic end_xfer(input logic [7:0] exp_rx, input int hp, input bit chk_slv,
                            input logic [7:0] exp_slv);
        bit ok;
        wait_rxv(ok);
        chk("rx_valid_seen", 32'(ok), 32'd1);
        chk("rx_data", 32'(bus.rx_data), 32'(exp_rx));
        chk("cs_n_at_done", 32'(cs_n), 32'd1);
        chk("busy_at_done", 32'(bus.busy), 32'd0);
        chk("tx_ready_at_done", 32'(bus.tx_ready), 32'd0);
        chk("sck_idle_level", 32'(sck), 32'(m_cpol));
        @(negedge clk);
        #1;
        chk("rx_valid_pulse", 32'(bus.rx_valid), 32'd0);
        chk("tx_ready_after", 32'(bus.tx_ready), 32'd1);
        chk("cs_low_cycles", 32'(cs_low), 32'(17 * hp));
        chk("sck_edges", 32'(sck_edges), 32'd16);
        chk("sck_rises", 32'(rises), 32'd8);
        chk("half_period_min", 32'(hp_min), 32'(hp));
        chk("half_period_max", 32'(hp_max), 32'(hp));
        chk("first_edge_delay", 32'(first_edge - cs_fall), 32'(hp));
        chk("last_edge_to_cs", 32'(cs_rise - last_edge), 32'(hp));
        chk("mosi_edge_align", 32'(bad_mosi), 32'd0);
        chk("rx_valid_count", 32'(rxv_cnt), 32'd1);
        if (chk_slv) chk("slave_rx", 32'(slv_rx), 32'(exp_slv));
        $display("xfer done: rx=%02h expected=%02h half_period=%0d cpol=%0b cpha=%0b",
                 bus.rx_data, exp_rx, hp, m_cpol, m_cpha);
    endtask

    initial begin
        bit ok;
        int n;
        rst_n        = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        bus.psc      = 4'd0;
        bus.cpol     = 1'b0;
        bus.cpha     = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cs_n", 32'(cs_n), 32'd1);
        chk("rst_sck", 32'(sck), 32'd0);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        chk("rst_rx_data", 32'(bus.rx_data), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_tx_ready", 32'(bus.tx_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("tx_ready_after_reset", 32'(bus.tx_ready), 32'd1);
        $display("reset released: tx_ready=%0b", bus.tx_ready);

        // Mode 0, fastest SCK, loopback
        start_xfer(8'hA5, 4'd0, 1'b0, 1'b0, 1'b1, 8'h00);
        end_xfer(8'hA5, 1, 1'b0, 8'h00);

        // Mode 3, psc=3, slave answers 0xC3; sck must idle high first
        bus.cpol = 1'b1;
        repeat (2) @(negedge clk);
        chk("mode3_idle_high", 32'(sck), 32'd1);
        start_xfer(8'h3C, 4'd3, 1'b1, 1'b1, 1'b0, 8'hC3);
        end_xfer(8'hC3, 4, 1'b1, 8'h3C);

        // Modes 1 and 2, psc=1, slave answers 0x7E
        start_xfer(8'h81, 4'd1, 1'b0, 1'b1, 1'b0, 8'h7E);
        end_xfer(8'h7E, 2, 1'b1, 8'h81);
        start_xfer(8'h81, 4'd1, 1'b1, 1'b0, 1'b0, 8'h7E);
        end_xfer(8'h7E, 2, 1'b1, 8'h81);

        // Back-to-back with tx_valid held high
        bus.psc  = 4'd0;
        bus.cpol = 1'b0;
        bus.cpha = 1'b0;
        m_cpol   = 1'b0;
        m_cpha   = 1'b0;
        loop_en  = 1'b1;
        clr_mon();
        send(8'h11, 1'b1);
        bus.tx_data = 8'h22;
        wait_rxv(ok);
        chk("b2b_first_rx_valid", 32'(ok), 32'd1);
        chk("b2b_first_rx_data", 32'(bus.rx_data), 32'h11);
        chk("b2b_tx_ready_at_rxv", 32'(bus.tx_ready), 32'd0);
        chk("b2b_cs_high_at_rxv", 32'(cs_n), 32'd1);
        @(negedge clk);
        chk("b2b_tx_ready_next", 32'(bus.tx_ready), 32'd1);
        chk("b2b_cs_high_gap", 32'(cs_n), 32'd1);
        @(negedge clk);
        chk("b2b_second_cs_low", 32'(cs_n), 32'd0);
        chk("b2b_second_busy", 32'(bus.busy), 32'd1);
        bus.tx_valid = 1'b0;
        wait_rxv(ok);
        chk("b2b_second_rx_valid", 32'(ok), 32'd1);
        chk("b2b_second_rx_data", 32'(bus.rx_data), 32'h22);
        @(negedge clk);
        #1;
        chk("b2b_rx_valid_count", 32'(rxv_cnt), 32'd2);
        $display("back-to-back done: second rx=%02h", bus.rx_data);

        // Config changed mid-transfer is ignored until the next word
        start_xfer(8'h5A, 4'd1, 1'b0, 1'b0, 1'b1, 8'h00);
        repeat (5) @(negedge clk);
        bus.psc  = 4'd7;
        bus.cpol = 1'b1;
        end_xfer(8'h5A, 2, 1'b0, 8'h00);
        start_xfer(8'hC6, 4'd7, 1'b1, 1'b0, 1'b1, 8'h00);
        end_xfer(8'hC6, 8, 1'b0, 8'h00);

        // One-cycle reset after the fifth SCK edge
        start_xfer(8'h96, 4'd1, 1'b0, 1'b0, 1'b1, 8'h00);
        n = 0;
        while (sck_edges < 5 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("edge5_reached", 32'(sck_edges >= 5), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_cs_n", 32'(cs_n), 32'd1);
        chk("abort_sck", 32'(sck), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_rx_data", 32'(bus.rx_data), 32'd0);
        chk("abort_rx_valid", 32'(bus.rx_valid), 32'd0);
        chk("abort_tx_ready", 32'(bus.tx_ready), 32'd0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        chk("abort_no_rx_valid", 32'(rxv_cnt), 32'd0);
        chk("abort_rx_data_held", 32'(bus.rx_data), 32'd0);
        $display("reset abort done: rx_valid pulses=%0d", rxv_cnt);
        start_xfer(8'h3C, 4'd1, 1'b0, 1'b0, 1'b1, 8'h00);
        end_xfer(8'h3C, 2, 1'b0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
